// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder.
// Glyph patterns are active-low {g,f,e,d,c,b,a}, matching the team hex encoder.
package seg7_scan_decoder_pkg;

    localparam logic [6:0] SEG7_GLYPH_0 = 7'h40;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'h79;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'h24;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'h30;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'h19;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'h12;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'h02;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'h78;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'h00;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'h10;
    localparam logic [6:0] SEG7_GLYPH_A = 7'h08;
    localparam logic [6:0] SEG7_GLYPH_B = 7'h03;
    localparam logic [6:0] SEG7_GLYPH_C = 7'h46;
    localparam logic [6:0] SEG7_GLYPH_D = 7'h21;
    localparam logic [6:0] SEG7_GLYPH_E = 7'h06;
    localparam logic [6:0] SEG7_GLYPH_F = 7'h0E;
    localparam logic [6:0] SEG7_BLANK   = 7'h7F;

endpackage

// File: rtl/seg7_scan_decoder_pattern_dec.sv
// Combinational inverse of the hex glyph table: raw segment pattern to nibble plus
// blank/error flags. Unknown patterns report err with nibble 0.
module seg7_pattern_dec
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_err,
    output logic       o_blank,
    output logic [3:0] o_nib
);

    always_comb begin
        o_err   = 1'b0;
        o_blank = 1'b0;
        o_nib   = 4'h0;
        case (i_pattern)
            SEG7_GLYPH_0: o_nib = 4'h0;
            SEG7_GLYPH_1: o_nib = 4'h1;
            SEG7_GLYPH_2: o_nib = 4'h2;
            SEG7_GLYPH_3: o_nib = 4'h3;
            SEG7_GLYPH_4: o_nib = 4'h4;
            SEG7_GLYPH_5: o_nib = 4'h5;
            SEG7_GLYPH_6: o_nib = 4'h6;
            SEG7_GLYPH_7: o_nib = 4'h7;
            SEG7_GLYPH_8: o_nib = 4'h8;
            SEG7_GLYPH_9: o_nib = 4'h9;
            SEG7_GLYPH_A: o_nib = 4'hA;
            SEG7_GLYPH_B: o_nib = 4'hB;
            SEG7_GLYPH_C: o_nib = 4'hC;
            SEG7_GLYPH_D: o_nib = 4'hD;
            SEG7_GLYPH_E: o_nib = 4'hE;
            SEG7_GLYPH_F: o_nib = 4'hF;
            SEG7_BLANK:   o_blank = 1'b1;
            default:      o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-seg bus and publishes debounced frames.
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int SETTLE  = 3,
    parameter int CONFIRM = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     dig_n,
`ifdef SEG7_SCAN_DP_EN
    input  logic                dp_n,
    output logic [NDIG-1:0]     out_dp,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_hex,
    output logic [NDIG-1:0]     out_blank,
    output logic [NDIG-1:0]     out_err,
    output logic                overrun
);

`ifdef SEG7_SCAN_DP_EN
    localparam int CW = 8;
    logic [CW-1:0] w_raw;
    assign w_raw = {dp_n, seg_n};
`else
    localparam int CW = 7;
    logic [CW-1:0] w_raw;
    assign w_raw = seg_n;
`endif

    logic [CW-1:0]       r_raw_s1, r_raw_s2;
    logic [NDIG-1:0]     r_dig_s1, r_dig_s2, r_dig_prev;
    logic [3:0]          r_settle;
    logic [CW-1:0]       r_cand [NDIG];
    logic [2:0]          r_cnt  [NDIG];
    logic [NDIG*CW-1:0]  r_last;
    logic                r_delivered;

    logic [3:0]          w_nlow;
    logic [2:0]          w_sel;
    logic                w_qual, w_sample, w_all_conf, w_pending, w_hs;
    logic [NDIG*CW-1:0]  w_cand_vec;
    logic [4*NDIG-1:0]   w_hex;
    logic [NDIG-1:0]     w_blank, w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_s1   <= '0;
            r_raw_s2   <= '0;
            r_dig_s1   <= '0;
            r_dig_s2   <= '0;
            r_dig_prev <= '0;
        end else begin
            r_raw_s1   <= w_raw;
            r_raw_s2   <= r_raw_s1;
            r_dig_s1   <= dig_n;
            r_dig_s2   <= r_dig_s1;
            r_dig_prev <= r_dig_s2;
        end
    end

    // Ghost guard: only a single, unchanged enable counts toward settling.
    always_comb begin
        w_nlow = 4'd0;
        w_sel  = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!r_dig_s2[i]) begin
                w_nlow = w_nlow + 4'd1;
                w_sel  = 3'(i);
            end
        end
    end

    assign w_qual   = (w_nlow == 4'd1) && (r_dig_s2 == r_dig_prev);
    assign w_sample = w_qual && (r_settle == 4'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (!w_qual) begin
            r_settle <= '0;
        end else if (r_settle != 4'(SETTLE)) begin
            r_settle <= r_settle + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                r_cand[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else if (w_sample) begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_sel == 3'(i)) begin
                    if (r_raw_s2 == r_cand[i]) begin
                        r_cnt[i] <= (r_cnt[i] == 3'(CONFIRM)) ? r_cnt[i] : r_cnt[i] + 3'd1;
                    end else begin
                        r_cand[i] <= r_raw_s2;
                        r_cnt[i]  <= 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_all_conf = 1'b1;
        w_cand_vec = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_cnt[i] != 3'(CONFIRM)) w_all_conf = 1'b0;
            w_cand_vec[i*CW +: CW] = r_cand[i];
        end
    end

    assign w_pending = w_all_conf && (!r_delivered || (w_cand_vec != r_last));
    assign w_hs      = out_valid && out_ready;

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg7_pattern_dec u_dec (
            .i_pattern (r_cand[g][6:0]),
            .o_err     (w_err[g]),
            .o_blank   (w_blank[g]),
            .o_nib     (w_hex[4*g +: 4])
        );
    end

`ifdef SEG7_SCAN_DP_EN
    logic [NDIG-1:0] w_dp;
    always_comb begin
        for (int i = 0; i < NDIG; i++) w_dp[i] = r_cand[i][7];
    end
`endif

    // Outputs hold while valid; a newer confirmed frame only reloads after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_hex     <= '0;
            out_blank   <= '0;
            out_err     <= '0;
            overrun     <= 1'b0;
            r_last      <= '0;
            r_delivered <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            out_dp      <= '0;
`endif
        end else if (out_valid) begin
            if (w_hs) begin
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else if (w_pending) begin
                overrun   <= 1'b1;
            end
        end else if (w_pending) begin
            out_valid   <= 1'b1;
            out_hex     <= w_hex;
            out_blank   <= w_blank;
            out_err     <= w_err;
            r_last      <= w_cand_vec;
            r_delivered <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
            out_dp      <= w_dp;
`endif
        end
    end

endmodule
